// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single wait-state memory bus.
// The instruction port is read-only; the data port can read or write. Every output is registered.
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int WAIT_STATE = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              MEnable,
  output logic              MRead,
  output logic              MWrite,
  output logic [ADDR_W-1:0] MAddress,
  output logic [DATA_W-1:0] MWriteData,
  input  logic [DATA_W-1:0] MReadData,
  input  logic              MReady
);

  localparam int CNT_MAX = (TIMEOUT > WAIT_STATE + 1) ? TIMEOUT : WAIT_STATE + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
  logic               seen_low, seen_low_next;
  logic               prefer_i, prefer_i_next;
  logic               sel_d, sel_d_next;
  logic               lat_we, lat_we_next;
  logic               pick_d;
  logic [ADDR_W-1:0]  addr_next;
  logic [DATA_W-1:0]  wdata_next, i_rdata_next, d_rdata_next;
  logic               i_gnt_next, d_gnt_next, i_done_next, d_done_next, err_next;
  logic               men_next, mrd_next, mwr_next;

  // Saturating increment so the counter can never wrap back to zero.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign pick_d  = d_req && (!i_req || !prefer_i);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    seen_low_next = seen_low;
    prefer_i_next = prefer_i;
    sel_d_next    = sel_d;
    lat_we_next   = lat_we;
    addr_next     = MAddress;
    wdata_next    = MWriteData;
    i_rdata_next  = i_rdata;
    d_rdata_next  = d_rdata;
    i_gnt_next    = 1'b0;
    d_gnt_next    = 1'b0;
    i_done_next   = 1'b0;
    d_done_next   = 1'b0;
    err_next      = 1'b0;
    men_next      = 1'b0;
    mrd_next      = 1'b0;
    mwr_next      = 1'b0;
    unique case (state)
      IDLE: begin
        // ISSUE-cycle outputs are loaded here so they are registered on entry.
        if (MReady && (i_req || d_req)) begin
          sel_d_next    = pick_d;
          prefer_i_next = pick_d;
          lat_we_next   = pick_d && d_we;
          addr_next     = pick_d ? d_addr : i_addr;
          wdata_next    = pick_d ? d_wdata : MWriteData;
          men_next      = 1'b1;
          mrd_next      = !(pick_d && d_we);
          mwr_next      = pick_d && d_we;
          i_gnt_next    = !pick_d;
          d_gnt_next    = pick_d;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next      = '0;
        seen_low_next = 1'b0;
        state_next    = lat_we ? WAIT_WR : WAIT_RD;
      end
      WAIT_WR: begin
        if (cnt == CNT_W'(WAIT_STATE)) begin
          d_done_next = sel_d;
          i_done_next = !sel_d;
          state_next  = DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      WAIT_RD: begin
        if (seen_low && MReady) begin
          if (sel_d) d_rdata_next = MReadData;
          else       i_rdata_next = MReadData;
          d_done_next = sel_d;
          i_done_next = !sel_d;
          state_next  = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_inc;
          if (!MReady) seen_low_next = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      seen_low   <= 1'b0;
      prefer_i   <= 1'b0;
      sel_d      <= 1'b0;
      lat_we     <= 1'b0;
      MAddress   <= '0;
      MWriteData <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      MEnable    <= 1'b0;
      MRead      <= 1'b0;
      MWrite     <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      seen_low   <= seen_low_next;
      prefer_i   <= prefer_i_next;
      sel_d      <= sel_d_next;
      lat_we     <= lat_we_next;
      MAddress   <= addr_next;
      MWriteData <= wdata_next;
      i_rdata    <= i_rdata_next;
      d_rdata    <= d_rdata_next;
      i_gnt      <= i_gnt_next;
      d_gnt      <= d_gnt_next;
      i_done     <= i_done_next;
      d_done     <= d_done_next;
      err        <= err_next;
      MEnable    <= men_next;
      MRead      <= mrd_next;
      MWrite     <= mwr_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench drives MReady/MReadData itself, and all expected values are worked out by hand.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt, i_done;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_done;
  logic [31:0] d_rdata;
  logic        err;
  logic        MEnable, MRead, MWrite;
  logic [15:0] MAddress;
  logic [31:0] MWriteData;
  logic [31:0] MReadData;
  logic        MReady;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.DATA_W(32), .ADDR_W(16), .WAIT_STATE(2), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .MEnable(MEnable), .MRead(MRead), .MWrite(MWrite),
    .MAddress(MAddress), .MWriteData(MWriteData),
    .MReadData(MReadData), .MReady(MReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int err_at;
    logic seen;

    reset = 1'b0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    MReadData = '0; MReady = 1'b1;
    tick();
    check("rst_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
    check("rst_done_err", {29'd0, i_done, d_done, err}, 32'd0);
    check("rst_mcmd", {29'd0, MEnable, MRead, MWrite}, 32'd0);
    check("rst_maddr", {16'd0, MAddress}, 32'd0);
    check("rst_mwdata", MWriteData, 32'd0);
    check("rst_rdata", i_rdata | d_rdata, 32'd0);
    tick();
    reset = 1'b1;

    // Data-port write: gnt one cycle after sampling, done four cycles after gnt.
    d_req = 1; d_we = 1; d_addr = 16'h0010; d_wdata = 32'hDEADBEEF;
    tick();
    check("wr_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
    check("wr_mcmd", {29'd0, MEnable, MRead, MWrite}, 32'd5);
    check("wr_maddr", {16'd0, MAddress}, 32'h0010);
    check("wr_mwdata", MWriteData, 32'hDEADBEEF);
    d_req = 0;
    tick();
    check("wr_gnt_pulse", {30'd0, i_gnt, d_gnt}, 32'd0);
    check("wr_men_off", {29'd0, MEnable, MRead, MWrite}, 32'd0);
    tick(); tick();
    check("wr_done_early", {30'd0, i_done, d_done}, 32'd0);
    tick();
    check("wr_done", {30'd0, i_done, d_done}, 32'd1);
    tick();
    check("wr_done_pulse", {30'd0, i_done, d_done}, 32'd0);
    check("wr_maddr_hold", {16'd0, MAddress}, 32'h0010);

    // Instruction read completing on the MReady rise that follows a fall.
    i_req = 1; i_addr = 16'h0004;
    tick();
    check("rd_gnt", {30'd0, i_gnt, d_gnt}, 32'd2);
    check("rd_mcmd", {29'd0, MEnable, MRead, MWrite}, 32'd6);
    check("rd_maddr", {16'd0, MAddress}, 32'h0004);
    i_req = 0;
    tick();
    MReady = 0;
    tick();
    check("rd_no_done_low", {30'd0, i_done, d_done}, 32'd0);
    MReady = 1; MReadData = 32'h12345678;
    tick();
    check("rd_done", {30'd0, i_done, d_done}, 32'd2);
    check("rd_rdata", i_rdata, 32'h12345678);
    check("rd_d_rdata", d_rdata, 32'd0);
    MReadData = 32'hFFFF0000;
    tick();
    check("rd_done_pulse", {30'd0, i_done, d_done}, 32'd0);
    check("rd_rdata_hold", i_rdata, 32'h12345678);

    // Both ports requesting from reset: d first, then i, then d again.
    reset = 0;
    i_req = 1; i_addr = 16'h0008; d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 32'h01020304;
    tick();
    check("rr_rst_rdata", i_rdata, 32'd0);
    reset = 1;
    tick();
    check("rr_gnt1", {30'd0, i_gnt, d_gnt}, 32'd1);
    tick(); tick(); tick(); tick();
    check("rr_done1", {30'd0, i_done, d_done}, 32'd1);
    tick(); tick();
    check("rr_gnt2", {30'd0, i_gnt, d_gnt}, 32'd2);
    check("rr_maddr2", {16'd0, MAddress}, 32'h0008);
    tick();
    MReady = 0;
    tick();
    MReady = 1; MReadData = 32'hA5A5A5A5;
    tick();
    check("rr_done2", {30'd0, i_done, d_done}, 32'd2);
    tick(); tick();
    check("rr_gnt3", {30'd0, i_gnt, d_gnt}, 32'd1);
    check("rr_maddr3", {16'd0, MAddress}, 32'h0020);
    i_req = 0; d_req = 0;
    tick(); tick(); tick(); tick();
    check("rr_done3", {30'd0, i_done, d_done}, 32'd1);
    tick();

    // Data read with MReady held high: error on the 16th edge after the grant.
    d_req = 1; d_we = 0; d_addr = 16'h0030;
    tick();
    check("to_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
    check("to_mcmd", {29'd0, MEnable, MRead, MWrite}, 32'd6);
    d_req = 0;
    err_at = 0; seen = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (d_done || i_done) seen = 1;
      if (err) begin
        err_at = k;
        break;
      end
    end
    check("to_err_cycle", err_at, 32'd16);
    check("to_no_done", {31'd0, seen}, 32'd0);
    tick();
    check("to_err_pulse", {31'd0, err}, 32'd0);
    check("to_d_rdata", d_rdata, 32'd0);

    // Reset in the middle of a read wait.
    i_req = 1; i_addr = 16'h0044;
    tick();
    check("ra_gnt", {30'd0, i_gnt, d_gnt}, 32'd2);
    i_req = 0;
    tick();
    MReady = 0;
    tick();
    reset = 0;
    #1;
    check("ra_rdata_zero", i_rdata, 32'd0);
    check("ra_maddr_zero", {16'd0, MAddress}, 32'd0);
    check("ra_mcmd_zero", {29'd0, MEnable, MRead, MWrite}, 32'd0);
    MReady = 1;
    tick(); tick();
    reset = 1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (i_done || d_done || err || i_gnt || d_gnt) seen = 1;
    end
    check("ra_quiet", {31'd0, seen}, 32'd0);
    d_req = 1; d_we = 1; d_addr = 16'h0050; d_wdata = 32'h0BADF00D;
    tick();
    check("ra_next_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
    check("ra_next_maddr", {16'd0, MAddress}, 32'h0050);
    d_req = 0;
    tick(); tick(); tick(); tick();
    check("ra_next_done", {30'd0, i_done, d_done}, 32'd1);
    tick();

    // A one-cycle d_req while busy must be lost without a trace.
    i_req = 1; i_addr = 16'h0060;
    tick();
    check("dp_gnt", {30'd0, i_gnt, d_gnt}, 32'd2);
    i_req = 0; d_req = 1; d_we = 1; d_addr = 16'h0070; d_wdata = 32'h77777777;
    tick();
    d_req = 0;
    MReady = 0;
    tick();
    MReady = 1; MReadData = 32'hCAFEBABE;
    tick();
    check("dp_i_done", {30'd0, i_done, d_done}, 32'd2);
    check("dp_i_rdata", i_rdata, 32'hCAFEBABE);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (d_gnt || MEnable || d_done) seen = 1;
    end
    check("dp_no_cmd", {31'd0, seen}, 32'd0);
    check("dp_maddr_hold", {16'd0, MAddress}, 32'h0060);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
